// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED mode sequencer: mode encoding,
// per-mode pattern seeds and the mode advance order.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2,
    BLINK = 2'd3
  } mode_e;

  localparam logic [3:0] PAT_IDLE  = 4'b0000;
  localparam logic [3:0] PAT_COUNT = 4'b0000;
  localparam logic [3:0] PAT_SHIFT = 4'b0001;
  localparam logic [3:0] PAT_BLINK = 4'b1111;

  function automatic mode_e next_mode(input mode_e m);
    unique case (m)
      IDLE:    return COUNT;
      COUNT:   return SHIFT;
      SHIFT:   return BLINK;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [3:0] init_pat(input mode_e m);
    unique case (m)
      IDLE:    return PAT_IDLE;
      COUNT:   return PAT_COUNT;
      SHIFT:   return PAT_SHIFT;
      default: return PAT_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces one active-low button: 2-FF sync, stability counter, and a
// registered one-cycle press pulse on each accepted press (not on release).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level is accepted once the synchronized value has disagreed for one
  // more cycle than the counter threshold, then the counter restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= ~btn_n_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank controller: debounced MODE/RUN buttons drive a mode/pause FSM
// that steps a 4-bit pattern on each divider tick; LEDs are active-low.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TICK_CYCLES     = 12_500_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] btn_n_i,
  output logic [3:0] led_n_o,
  output logic [1:0] mode_o,
  output logic       paused_o
);

  localparam int TW = $clog2(TICK_CYCLES);

  logic [1:0]    btn_level, btn_press;
  logic          mode_press, run_press, tick;
  mode_e         mode_q, mode_d;
  logic          paused_q, paused_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    led_n_q, led_n_d;
  logic [TW-1:0] tick_q, tick_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_n_i (btn_n_i[0]),
    .level_o (btn_level[0]),
    .press_o (btn_press[0])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_n_i (btn_n_i[1]),
    .level_o (btn_level[1]),
    .press_o (btn_press[1])
  );

  // A press pulse is only honoured while its button is still seen held.
  assign mode_press = btn_press[0] & btn_level[0];
  assign run_press  = btn_press[1] & btn_level[1];
  assign tick       = (mode_q != IDLE) && !paused_q && (tick_q == TW'(TICK_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q   <= IDLE;
      paused_q <= 1'b0;
      pat_q    <= PAT_IDLE;
      led_n_q  <= 4'b1111;
      tick_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      paused_q <= paused_d;
      pat_q    <= pat_d;
      led_n_q  <= led_n_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    paused_d = paused_q;
    pat_d    = pat_q;
    tick_d   = tick_q;
    if (mode_q == IDLE) begin
      tick_d = '0;
    end else if (!paused_q) begin
      tick_d = tick ? '0 : tick_q + TW'(1);
    end
    if (tick) begin
      unique case (mode_q)
        COUNT:   pat_d = pat_q + 4'd1;
        SHIFT:   pat_d = {pat_q[2:0], pat_q[3]};
        BLINK:   pat_d = ~pat_q;
        default: pat_d = pat_q;
      endcase
    end
    if (run_press && (mode_q != IDLE)) begin
      paused_d = ~paused_q;
    end
    // Mode entry overrides any same-cycle step or pause toggle.
    if (mode_press) begin
      mode_d   = next_mode(mode_q);
      pat_d    = init_pat(next_mode(mode_q));
      tick_d   = '0;
      paused_d = 1'b0;
    end
    led_n_d = ~pat_d;
  end

  always_comb begin
    led_n_o  = led_n_q;
    mode_o   = mode_q;
    paused_o = paused_q;
  end

endmodule
